// File: rtl/puf_pkg.sv
// Shared types and helpers for the RO-PUF evaluation sequencer.
// Holds the phase enum, default sizing and the pair-select helper.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    COMPARE,
    DONE
  } state_e;

  localparam int N_BITS_DEF     = 8;
  localparam int SEL_W_DEF      = 5;
  localparam int CNT_W_DEF      = 8;
  localparam int WINDOW_DEF     = 64;
  localparam int CLR_CYC_DEF    = 2;
  localparam int SETTLE_CYC_DEF = 4;

  localparam int PAIR_W = 16;

  // Returns {sel_b, sel_a}; the caller keeps the low SEL_W bits of each
  // half, which gives the modulo-2^SEL_W wrap for free.
  function automatic logic [2*PAIR_W-1:0] next_pair(
    input logic [PAIR_W-1:0] base,
    input logic [4:0]        idx
  );
    logic [PAIR_W-1:0] a;
    logic [PAIR_W-1:0] b;
    a = base + {10'd0, idx, 1'b0};
    b = a + 16'd1;
    return {b, a};
  endfunction

endpackage

// File: rtl/puf_eval_ctrl_timer.sv
// Loadable down-counter with zero flag, shared by the
// CLEAR, RUN and SETTLE phases of each race.
module puf_phase_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/puf_eval_ctrl.sv
// RO-PUF evaluation sequencer: runs one oscillator-pair race per
// response bit and assembles the response word.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int N_BITS     = N_BITS_DEF,
  parameter int SEL_W      = SEL_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WINDOW     = WINDOW_DEF,
  parameter int CLR_CYC    = CLR_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  challenge,
  input  logic [CNT_W-1:0]  cnt_a,
  input  logic [CNT_W-1:0]  cnt_b,
  output logic              ro_en,
  output logic              cnt_clr,
  output logic [SEL_W-1:0]  sel_a,
  output logic [SEL_W-1:0]  sel_b,
  output logic              busy,
  output logic              resp_valid,
  output logic [N_BITS-1:0] response,
  output logic              tie_seen,
  output logic              sat_seen
);

  localparam int TMAX =
    (WINDOW > CLR_CYC)
      ? ((WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC)
      : ((CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC);
  localparam int TW = $clog2(TMAX + 1);
  localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [TW-1:0]    T_CLR   = TW'(CLR_CYC - 1);
  localparam logic [TW-1:0]    T_RUN   = TW'(WINDOW - 1);
  localparam logic [TW-1:0]    T_SET   = TW'(SETTLE_CYC - 1);
  localparam logic [IW-1:0]    LAST    = IW'(N_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    chal_q, chal_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       idx_nx;
  logic                ro_en_q, ro_en_d;
  logic                cnt_clr_q, cnt_clr_d;
  logic [SEL_W-1:0]    sel_a_q, sel_a_d;
  logic [SEL_W-1:0]    sel_b_q, sel_b_d;
  logic                busy_q, busy_d;
  logic                rv_q, rv_d;
  logic [N_BITS-1:0]   resp_q, resp_d;
  logic                tie_q, tie_d;
  logic                sat_q, sat_d;
  logic [2*PAIR_W-1:0] pair;

  logic                t_load;
  logic [TW-1:0]       t_val;
  logic                t_zero;

  puf_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    idx_d   = idx_q;
    idx_nx  = idx_q + IW'(1);
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    sat_d   = sat_q;
    t_load  = 1'b0;
    t_val   = '0;
    pair    = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          chal_d  = challenge;
          resp_d  = '0;
          tie_d   = 1'b0;
          sat_d   = 1'b0;
          idx_d   = '0;
          state_d = CLEAR;
          t_load  = 1'b1;
          t_val   = T_CLR;
          pair    = next_pair(PAIR_W'(challenge), 5'd0);
          sel_a_d = pair[SEL_W-1:0];
          sel_b_d = pair[PAIR_W +: SEL_W];
        end
      end
      CLEAR: begin
        if (t_zero) begin
          state_d = RUN;
          t_load  = 1'b1;
          t_val   = T_RUN;
        end
      end
      RUN: begin
        if (t_zero) begin
          state_d = SETTLE;
          t_load  = 1'b1;
          t_val   = T_SET;
        end
      end
      SETTLE: begin
        if (t_zero) begin
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        resp_d[idx_q] = (cnt_a > cnt_b);
        if (cnt_a == cnt_b) begin
          tie_d = 1'b1;
        end
        if ((cnt_a == CNT_MAX) || (cnt_b == CNT_MAX)) begin
          sat_d = 1'b1;
        end
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_nx;
          state_d = CLEAR;
          t_load  = 1'b1;
          t_val   = T_CLR;
          pair    = next_pair(PAIR_W'(chal_q), 5'(idx_nx));
          sel_a_d = pair[SEL_W-1:0];
          sel_b_d = pair[PAIR_W +: SEL_W];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered copies of the phase being entered.
    ro_en_d   = (state_d == RUN);
    cnt_clr_d = (state_d == CLEAR);
    busy_d    = (state_d != IDLE);
    rv_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      chal_q    <= '0;
      idx_q     <= '0;
      ro_en_q   <= 1'b0;
      cnt_clr_q <= 1'b0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
      resp_q    <= '0;
      tie_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      chal_q    <= chal_d;
      idx_q     <= idx_d;
      ro_en_q   <= ro_en_d;
      cnt_clr_q <= cnt_clr_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      busy_q    <= busy_d;
      rv_q      <= rv_d;
      resp_q    <= resp_d;
      tie_q     <= tie_d;
      sat_q     <= sat_d;
    end
  end

  assign ro_en      = ro_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign sel_a      = sel_a_q;
  assign sel_b      = sel_b_q;
  assign busy       = busy_q;
  assign resp_valid = rv_q;
  assign response   = resp_q;
  assign tie_seen   = tie_q;
  assign sat_seen   = sat_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl with a behavioural counter model
// and randomized challenges and counts.
module tb_puf_eval_ctrl;

  localparam int N_BITS  = 8;
  localparam int CLR_CYC = 2;
  localparam int WINDOW  = 64;
  localparam int LAT     = 1 + N_BITS * (CLR_CYC + WINDOW + 4 + 1);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] challenge;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic       ro_en;
  logic       cnt_clr;
  logic [4:0] sel_a;
  logic [4:0] sel_b;
  logic       busy;
  logic       resp_valid;
  logic [7:0] response;
  logic       tie_seen;
  logic       sat_seen;

  puf_eval_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .challenge  (challenge),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .ro_en      (ro_en),
    .cnt_clr    (cnt_clr),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .busy       (busy),
    .resp_valid (resp_valid),
    .response   (response),
    .tie_seen   (tie_seen),
    .sat_seen   (sat_seen)
  );

  typedef struct {
    logic [7:0] resp;
    logic       tie;
    logic       sat;
    int         t0;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] ta[8];
  logic [7:0] tb_v[8];
  logic [4:0] cur_chal;
  int         cyc;
  int         n_chk;
  int         n_fail;
  int         n_valid;
  int         drv_race;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    e.resp = '0;
    e.tie  = 1'b0;
    e.sat  = 1'b0;
    e.t0   = 0;
    for (int i = 0; i < N_BITS; i++) begin
      e.resp[i] = (ta[i] > tb_v[i]);
      if (ta[i] == tb_v[i]) e.tie = 1'b1;
      if (ta[i] == 8'hFF || tb_v[i] == 8'hFF) e.sat = 1'b1;
    end
    return e;
  endfunction

  // Counter model: zero while cleared, noise while oscillating,
  // then the table value for the current race once ro_en drops.
  initial begin
    logic prev_clr;
    prev_clr = 1'b0;
    drv_race = 0;
    cnt_a = '0;
    cnt_b = '0;
    forever begin
      @(negedge clk);
      if (!busy) drv_race = 0;
      if (cnt_clr && !prev_clr) drv_race++;
      prev_clr = cnt_clr;
      if (cnt_clr) begin
        cnt_a = '0;
        cnt_b = '0;
      end else if (ro_en) begin
        cnt_a = 8'($urandom);
        cnt_b = 8'($urandom);
      end else if (drv_race > 0 && drv_race <= N_BITS) begin
        cnt_a = ta[drv_race-1];
        cnt_b = tb_v[drv_race-1];
      end
    end
  end

  // Monitor: phase lengths, pair selects and scoreboard pops.
  initial begin
    int   clr_len;
    int   run_len;
    int   mon_race;
    logic p_clr;
    logic p_run;
    logic p_rv;
    logic [4:0] ea;
    exp_t e;
    clr_len  = 0;
    run_len  = 0;
    mon_race = 0;
    p_clr    = 1'b0;
    p_run    = 1'b0;
    p_rv     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        clr_len  = 0;
        run_len  = 0;
        mon_race = 0;
        p_clr    = 1'b0;
        p_run    = 1'b0;
        p_rv     = 1'b0;
        continue;
      end
      if (!busy) mon_race = 0;
      if (cnt_clr && !p_clr) mon_race++;
      ea = 5'(cur_chal + 5'(2 * (mon_race - 1)));
      if ((cnt_clr && !p_clr) || (p_run && !ro_en)) begin
        chk("sel_a", 32'(sel_a), 32'(ea));
        chk("sel_b", 32'(sel_b), 32'(5'(ea + 5'd1)));
      end
      if (cnt_clr && ro_en) chk("clr_and_ro_en", 32'd1, 32'd0);
      if (cnt_clr) clr_len++;
      else if (clr_len != 0) begin
        chk("cnt_clr_len", 32'(clr_len), 32'(CLR_CYC));
        clr_len = 0;
      end
      if (ro_en) run_len++;
      else if (run_len != 0) begin
        chk("ro_en_len", 32'(run_len), 32'(WINDOW));
        run_len = 0;
      end
      if (p_rv) chk("rv_pulse", 32'(resp_valid), 32'd0);
      if (resp_valid) begin
        n_valid++;
        if (sbq.size() == 0) begin
          chk("unexpected_rv", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("response", 32'(response), 32'(e.resp));
          chk("tie_seen", 32'(tie_seen), 32'(e.tie));
          chk("sat_seen", 32'(sat_seen), 32'(e.sat));
          chk("latency", 32'(cyc - e.t0), 32'(LAT));
          chk("busy_at_rv", 32'(busy), 32'd1);
        end
      end
      p_clr = cnt_clr;
      p_run = ro_en;
      p_rv  = resp_valid;
    end
  end

  task automatic issue(input logic [4:0] ch);
    exp_t e;
    e = model();
    cur_chal = ch;
    @(posedge clk);
    #1;
    start     = 1'b1;
    challenge = ch;
    e.t0      = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    start     = 1'b0;
    challenge = 5'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", 32'(sbq.size()), 32'd0);
    sbq.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < N_BITS; i++) begin
      ta[i]   = a;
      tb_v[i] = b;
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ro_en"}, 32'(ro_en), 32'd0);
    chk({tag, "_cnt_clr"}, 32'(cnt_clr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_response"}, 32'(response), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    int   t0;
    exp_t e;
    n_chk     = 0;
    n_fail    = 0;
    n_valid   = 0;
    cur_chal  = '0;
    start     = 1'b0;
    challenge = '0;
    rst_n     = 1'b0;
    fill(8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #2;
    chk_idle_zero("rst");
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_tie", 32'(tie_seen), 32'd0);
    chk("rst_sat", 32'(sat_seen), 32'd0);
    chk("rst_sel", 32'({sel_a, sel_b}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    fill(8'd100, 8'd90);
    issue(5'd4);
    wait_done();

    for (int i = 0; i < N_BITS; i++) begin
      ta[i]   = (i % 2 == 0) ? 8'd120 : 8'd30;
      tb_v[i] = (i % 2 == 0) ? 8'd60  : 8'd200;
    end
    issue(5'd28);
    wait_done();

    fill(8'd77, 8'd12);
    ta[3]   = 8'd50;
    tb_v[3] = 8'd50;
    issue(5'd9);
    wait_done();

    fill(8'd40, 8'd20);
    tb_v[0] = 8'hFF;
    issue(5'd17);
    wait_done();
    fill(8'd40, 8'd20);
    issue(5'd17);
    wait_done();

    n = n_valid;
    fill(8'd5, 8'd6);
    issue(5'd31);
    t0 = cyc;
    while (cyc < t0 + 99) @(posedge clk);
    #1;
    start     = 1'b1;
    challenge = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (700) @(posedge clk);
    chk("ignored_start_count", 32'(n_valid - n), 32'd1);

    fill(8'd200, 8'd100);
    issue(5'd11);
    n = 0;
    while (!(drv_race == 6 && ro_en) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("reach_race5", 32'(n < 1000), 32'd1);
    repeat (10) @(posedge clk);
    #2;
    chk("pre_rst_ro_en", 32'(ro_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_zero("async_rst");
    sbq.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    fill(8'd10, 8'd250);
    issue(5'd11);
    wait_done();

    fill(8'd33, 8'd32);
    n = n_valid;
    e = model();
    cur_chal = 5'd6;
    @(posedge clk);
    #1;
    start     = 1'b1;
    challenge = 5'd6;
    t0 = cyc;
    e.t0 = t0;
    sbq.push_back(e);
    e.t0 = t0 + LAT + 1;
    sbq.push_back(e);
    while (cyc < t0 + LAT + 6) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    chk("held_start_count", 32'(n_valid - n), 32'd2);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N_BITS; i++) begin
        ta[i]   = 8'($urandom);
        tb_v[i] = 8'($urandom);
        if ($urandom_range(5) == 0) tb_v[i] = ta[i];
        if ($urandom_range(9) == 0) ta[i] = 8'hFF;
      end
      issue(5'($urandom));
      wait_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
- Sequencer for the ring-oscillator PUF datapath: the oscillator bank, the two pair-select muxes, the two 8-bit edge counters and the comparator.
- For one challenge it runs N_BITS oscillator-pair races. Each race: clear counters, enable oscillators for a fixed clk window, let counters settle, compare.
- The race outcomes are assembled into a response word with a start/busy/valid handshake.
- It sits between the host/user IO and the PUF core. It is the only block that drives oscillator enable, counter clear and pair selects.

Parameters:
- N_BITS, 8, response bits per evaluation (1..16).
- SEL_W, 5, pair-select width (oscillator index space 2^SEL_W).
- CNT_W, 8, width of counter inputs.
- WINDOW, 64, clk cycles that ro_en is held high per race (>=1).
- CLR_CYC, 2, clk cycles cnt_clr is held high before each race (>=1).
- SETTLE_CYC, 4, clk cycles after ro_en falls before counts are sampled (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request evaluation; sampled in IDLE only
- challenge  in  SEL_W  base oscillator index; latched on accepted start
- cnt_a  in  CNT_W  count from counter on mux A
- cnt_b  in  CNT_W  count from counter on mux B
- ro_en  out  1  oscillator enable
- cnt_clr  out  1  counter clear, active high
- sel_a  out  SEL_W  mux A select
- sel_b  out  SEL_W  mux B select
- busy  out  1  evaluation in progress
- resp_valid  out  1  one-cycle pulse: response is complete
- response  out  N_BITS  response word; held until next accepted start
- tie_seen  out  1  at least one race had cnt_a == cnt_b
- sat_seen  out  1  at least one race had a count equal to all-ones

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous, active-low; all state resets immediately on assertion.
- Reset values: state = IDLE; ro_en, cnt_clr, busy, resp_valid, tie_seen, sat_seen = 0; response = 0; sel_a = sel_b = 0; bit_idx = 0; timer = 0.
- All outputs are registered.
- Pair selection for race i:
  - sel_a = (chal_q + 2*i) mod 2^SEL_W
  - sel_b = (sel_a + 1) mod 2^SEL_W, wraps (31 -> 0)
  - selects are stable from CLEAR entry through COMPARE.
- State machine:
  - IDLE: if start, latch chal_q; clear response, tie_seen, sat_seen; set bit_idx = 0; go to CLEAR. busy rises on the next edge. A start while busy is ignored; there is no queueing.
  - CLEAR: cnt_clr = 1, ro_en = 0 for exactly CLR_CYC cycles, then go to RUN.
  - RUN: cnt_clr = 0, ro_en = 1 for exactly WINDOW cycles, then go to SETTLE.
  - SETTLE: ro_en = 0 for SETTLE_CYC cycles. cnt_a/cnt_b come from an asynchronous domain and are valid only after this state; no other synchronization is required.
  - COMPARE (1 cycle):
    - response[bit_idx] = (cnt_a > cnt_b), unsigned; a tie gives 0 and sets tie_seen.
    - If either count == 2^CNT_W-1, set sat_seen (sticky until next start).
    - If bit_idx == N_BITS-1, go to DONE; else increment bit_idx and go to CLEAR.
  - DONE (1 cycle): resp_valid = 1, busy = 0 on the next edge, then go to IDLE.
- Per-race latency: CLR_CYC + WINDOW + SETTLE_CYC + 1 cycles.
- Total latency from start accepted to resp_valid: 1 + N_BITS*(CLR_CYC+WINDOW+SETTLE_CYC+1) cycles. Default: 1 + 8*71 = 569.
- start held high through DONE is accepted again in the IDLE cycle after DONE.
- Reset mid-evaluation drops ro_en and cnt_clr immediately and discards the partial response.
- The timer is a single down-counter sized for max(WINDOW, CLR_CYC, SETTLE_CYC).

Decomposition:
- Shared package puf_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE)
  - default parameter constants
  - a next_pair function computing sel_a/sel_b from base and index.
- One sub-module, puf_phase_timer: loadable down-counter with a zero flag, reused for all three timed phases.

Test Plan:
- Default parameters, challenge = 5'd4, cnt_a model = 100, cnt_b model = 90 every race -> response = 8'hFF, resp_valid pulses exactly 569 cycles after start, tie_seen = 0, sat_seen = 0.
- Challenge = 5'd28, alternating races a>b / a<b -> response = 8'h55. Races 2 and 3 must show sel_a/sel_b = 0/1 and 2/3 (wrap-around check).
- cnt_a == cnt_b == 8'd50 on race 3 only, a>b otherwise -> response = 8'hF7, tie_seen = 1.
- cnt_b = 8'hFF on race 0 -> response bit 0 = 0, sat_seen = 1. Second start with clean counts -> sat_seen cleared to 0.
- start pulsed again at cycle 100 of a busy evaluation -> ignored; only one resp_valid pulse. ro_en high time per race is exactly 64 cycles, cnt_clr exactly 2.
- rst_n driven low during RUN of race 5 -> ro_en, busy and response go to 0 without waiting for clk. Evaluation restarted after reset completes normally.
